can_tx_serializer: RTL

Transmit-side bit engine for the CAN controller. It sits beside the receive timing block and reuses its per-bit strobes: `tx_strobe` marks the start of a bit and `bitstrobe` marks the sample point. It takes a latched standard (11-bit ID) data/remote frame and serializes it onto `tx`, inserting stuff bits and appending CRC-15. It checks the bus read-back at every sample point for arbitration loss, bit errors and a missing ACK.

---
 rtl/can_pkg.sv | 33 +++
 rtl/can_crc15.sv | 27 ++
 rtl/can_tx_serializer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// can_pkg: shared state type, constants and helpers for the CAN transmit path.
// The arbitration option (CAN_TX_ARB_EN) is selected in can_tx_serializer.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF_WAIT,
    ST_SOF,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } can_tx_state_t;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam int CAN_STUFF_LIMIT = 5;
  localparam int CAN_EOF_BITS = 7;
  localparam int CAN_IFS_BITS = 3;

  function automatic logic can_stuffed(can_tx_state_t s);
    return s inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  endfunction

  function automatic logic can_crc_fed(can_tx_state_t s);
    return s inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA};
  endfunction

endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CRC-15 accumulator, one bit per enabled clock.
// Cleared at frame start, fed MSB-first with unstuffed frame bits.
module can_crc15 (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [14:0] crc
);
  import can_pkg::*;

  logic fb;

  assign fb = din ^ crc[14];

  always_ff @(posedge clk) begin
    if (!nRST) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[13:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : 15'h0);
    end
  end

endmodule

// File: rtl/can_tx_serializer.sv
// can_tx_serializer: CAN 2.0A transmitter with bit stuffing, CRC-15, read-back checks.
// Define CAN_TX_ARB_EN to report arbitration loss instead of a bit error.
module can_tx_serializer #(
  parameter int MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        tx_strobe,
  input  logic        bitstrobe,
  input  logic        rx_bit,
  input  logic        start,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        arb_lost,
  output logic        bit_err,
  output logic        ack_err
);
  import can_pkg::*;

`ifdef CAN_TX_ARB_EN
  localparam bit ARB_EN = 1'b1;
`else
  localparam bit ARB_EN = 1'b0;
`endif
  localparam int CAP = (MAX_BYTES > 8) ? 8 : MAX_BYTES;

  can_tx_state_t state_q, state_d, nxt_state;
  logic [6:0]  cnt_q, cnt_d, nxt_cnt;
  logic [2:0]  run_q, run_d;
  logic        tx_q, tx_d, busy_q, busy_d;
  logic        done_q, done_d, arb_q, arb_d;
  logic        berr_q, berr_d, aerr_q, aerr_d;
  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [6:0]  nbits_q;
  logic [3:0]  nbytes;
  logic [14:0] crc;
  logic        crc_clr, crc_en, crc_din;
  logic        accept, chk_on, arb_hit, ack_hit, bit_hit;
  logic        err, adv, stuff_due, nbit;

  can_crc15 u_crc (
    .clk    (clk),
    .nRST   (nRST),
    .clear  (crc_clr),
    .enable (crc_en),
    .din    (crc_din),
    .crc    (crc)
  );

  assign nbytes = rtr ? 4'd0 : (dlc > 4'(CAP)) ? 4'(CAP) : dlc;

  assign accept = (state_q == ST_IDLE) && start;
  assign chk_on = bitstrobe &&
    !(state_q inside {ST_IDLE, ST_SOF_WAIT, ST_IFS});
  assign arb_hit = chk_on && ARB_EN && (state_q == ST_ARB) &&
    tx_q && !rx_bit;
  assign ack_hit = chk_on && (state_q == ST_ACK_SLOT) && rx_bit;
  assign bit_hit = chk_on && (state_q != ST_ACK_SLOT) && !arb_hit &&
    (rx_bit != tx_q);
  assign err = arb_hit || ack_hit || bit_hit;
  assign adv = tx_strobe && (state_q != ST_IDLE) && !err;
  assign stuff_due = can_stuffed(state_q) &&
    (run_q == 3'(CAN_STUFF_LIMIT));

  always_comb begin
    nxt_state = state_q;
    nxt_cnt = cnt_q + 7'd1;
    unique case (state_q)
      ST_SOF_WAIT: begin nxt_state = ST_SOF; nxt_cnt = '0; end
      ST_SOF:      begin nxt_state = ST_ARB; nxt_cnt = '0; end
      ST_ARB: if (cnt_q == 7'd11) begin
        nxt_state = ST_CTRL;
        nxt_cnt = '0;
      end
      ST_CTRL: if (cnt_q == 7'd5) begin
        nxt_state = (nbits_q == '0) ? ST_CRC : ST_DATA;
        nxt_cnt = '0;
      end
      ST_DATA: if (cnt_q == nbits_q - 7'd1) begin
        nxt_state = ST_CRC;
        nxt_cnt = '0;
      end
      ST_CRC: if (cnt_q == 7'd14) begin
        nxt_state = ST_CRC_DEL;
        nxt_cnt = '0;
      end
      ST_CRC_DEL:  begin nxt_state = ST_ACK_SLOT; nxt_cnt = '0; end
      ST_ACK_SLOT: begin nxt_state = ST_ACK_DEL; nxt_cnt = '0; end
      ST_ACK_DEL:  begin nxt_state = ST_EOF; nxt_cnt = '0; end
      ST_EOF: if (cnt_q == 7'(CAN_EOF_BITS - 1)) begin
        nxt_state = ST_IFS;
        nxt_cnt = '0;
      end
      ST_IFS: if (cnt_q == 7'(CAN_IFS_BITS - 1)) begin
        nxt_state = ST_IDLE;
        nxt_cnt = '0;
      end
      default: begin nxt_state = ST_IDLE; nxt_cnt = '0; end
    endcase
  end

  always_comb begin
    nbit = 1'b1;
    unique case (nxt_state)
      ST_SOF:  nbit = 1'b0;
      ST_ARB:  nbit = (nxt_cnt == 7'd11) ? rtr_q :
                      id_q[4'd10 - nxt_cnt[3:0]];
      ST_CTRL: nbit = (nxt_cnt < 7'd2) ? 1'b0 :
                      dlc_q[2'(3'd5 - nxt_cnt[2:0])];
      ST_DATA: nbit = data_q[~nxt_cnt[5:0]];
      ST_CRC:  nbit = crc[4'd14 - nxt_cnt[3:0]];
      default: nbit = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    run_d = run_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    arb_d = 1'b0;
    berr_d = 1'b0;
    aerr_d = 1'b0;
    crc_clr = 1'b0;
    crc_en = 1'b0;
    crc_din = 1'b0;
    unique case (1'b1)
      accept: begin
        state_d = ST_SOF_WAIT;
        busy_d = 1'b1;
        cnt_d = '0;
        run_d = '0;
        crc_clr = 1'b1;
      end
      err: begin
        state_d = ST_IDLE;
        busy_d = 1'b0;
        tx_d = 1'b1;
        cnt_d = '0;
        run_d = '0;
        arb_d = arb_hit;
        aerr_d = ack_hit;
        berr_d = bit_hit;
      end
      adv: begin
        if (stuff_due) begin
          // stuff bit: field position and CRC hold
          tx_d = ~tx_q;
          run_d = 3'd1;
        end else begin
          state_d = nxt_state;
          cnt_d = nxt_cnt;
          tx_d = nbit;
          run_d = !can_stuffed(nxt_state) ? 3'd0 :
                  (nbit == tx_q) ? run_q + 3'd1 : 3'd1;
          crc_en = can_crc_fed(nxt_state);
          crc_din = nbit;
          if (nxt_state == ST_IDLE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      run_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      arb_q <= 1'b0;
      berr_q <= 1'b0;
      aerr_q <= 1'b0;
      id_q <= '0;
      rtr_q <= 1'b0;
      dlc_q <= '0;
      data_q <= '0;
      nbits_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      arb_q <= arb_d;
      berr_q <= berr_d;
      aerr_q <= aerr_d;
      if (accept) begin
        id_q <= id;
        rtr_q <= rtr;
        dlc_q <= dlc;
        data_q <= data;
        nbits_q <= {nbytes, 3'b000};
      end
    end
  end

  assign tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign arb_lost = arb_q;
  assign bit_err = berr_q;
  assign ack_err = aerr_q;

endmodule
